fir_stimgen_param: RTL and testbench
====================================

FIR_STIMGEN_PARAM -- requirements
Module: fir_stimgen_param

Interface
REQ-001 Parameters SHALL be (one per line: name, default, meaning):
- DATA_W, 16, sample width in bits, two's complement.
- DEPTH, 8, table entries; legal range 2..256.
- ADDR_W, $clog2(DEPTH), index width (derived).
REQ-002 Ports SHALL be (name, direction, width, meaning), clock and reset first:
- system1000, in, 1, sole clock, rising edge.
- system1000_rst, in, 1, reset, synchronous, active-high.
- start, in, 1, pulse; begin the sequence at index 0.
- stop, in, 1, pulse; return to IDLE.
- mode, in, 2, end-of-sequence behaviour, sampled at start.
- len, in, ADDR_W+1, sequence length, sampled at start; 0 or >DEPTH means DEPTH.
- wr_en, in, 1, table write strobe.
- wr_addr, in, ADDR_W, table write address.
- wr_data, in, DATA_W signed, table write data.
- out_valid, out, 1, sample valid.
- out_ready, in, 1, downstream accepts sample.
- out_data, out, DATA_W signed, current sample.
- done, out, 1, one-cycle pulse when the last entry is accepted.

Function
REQ-003 Modes SHALL be: HOLD=0 (repeat the last entry forever), LOOP=1 (wrap to index 0), ZERO=2 (emit 0 forever); 3 SHALL behave as HOLD.
REQ-004 The state machine SHALL have three states:
- IDLE: out_valid=0, out_data=0.
- RUN: out_valid=1, out_data=table[idx].
- TAIL: out_valid=1, out_data=table[len_q-1] in HOLD or 0 in ZERO.
REQ-005 start SHALL move any state to RUN the next cycle, with idx=0 and len_q/mode_q latched; a start in RUN restarts the sequence.
REQ-006 stop SHALL move any state to IDLE the next cycle; when start and stop are asserted together, stop SHALL win.
REQ-007 In RUN, idx SHALL advance by 1 only in a cycle where out_valid and out_ready are both high; otherwise out_data SHALL be held stable.
REQ-008 When idx=len_q-1 is accepted, done SHALL pulse high for that cycle, and:
- LOOP: idx returns to 0 and the state stays RUN.
- HOLD or ZERO: the state moves to TAIL.
REQ-009 In TAIL, handshakes SHALL be accepted but SHALL NOT change state or data; done SHALL stay low.
REQ-010 out_data SHALL be driven combinationally from state, idx and the table; the latency from start to the first valid sample SHALL be 1 cycle.
REQ-011 A table write SHALL become visible on out_data in the cycle after wr_en; writes SHALL be allowed in every state.
REQ-012 Index arithmetic SHALL use ADDR_W+1 bits to avoid overflow when len_q=DEPTH; DEPTH need not be a power of two.

Reset
REQ-013 On system1000_rst, the block SHALL enter IDLE with idx=0, done=0, out_valid=0, out_data=0, mode_q=HOLD and len_q=DEPTH.
REQ-014 Reset SHALL load the table with FIR_types default stimulus {2,3,-2,8} at indices 0..3 and zeros elsewhere.
REQ-015 Reset asserted mid-sequence SHALL override start, stop and wr_en in the same cycle.

Structure
REQ-016 Package FIR_types SHALL hold the mode enum, the default stimulus constant and the state enum.
REQ-017 Table storage plus its reset-load logic SHALL be the sub-module fir_stimgen_table, with a write port and a combinational read port.

Verification
REQ-018 Reset, then start with len=4, mode=HOLD, ready=1 -> out_data 2,3,-2,8,8,8...; done high on the cycle 8 is accepted.
REQ-019 Start with len=4, mode=LOOP, ready=1 -> 2,3,-2,8,2,3...; done pulses every 4 cycles.
REQ-020 Start with len=3, mode=ZERO, ready toggling 1,0 -> each value is held while ready=0, and the sequence is 2,2,3,3,-2,-2,0...
REQ-021 Write table[1]=100 during RUN while idx=1 with ready=0 -> out_data=100 from the next cycle.
REQ-022 Start and stop together in RUN -> IDLE next cycle with out_valid=0; start with len=0 -> all 8 entries played (4 defaults, then 0,0,0,0).
REQ-023 Assert reset at idx=2 in LOOP after writing table[0]=7 -> IDLE, and the next start yields 2 (table reloaded).

Source files
------------

// File: rtl/fir_stimgen_param_pkg.sv
// Shared types and constants for the FIR stimulus generator: the
// end-of-sequence mode, the sequencer state, and the default stimulus
// loaded into the table on reset.
package FIR_types;

  // End-of-sequence behaviour; code 3 is treated as HOLD
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_LOOP  = 2'd1,
    MODE_ZERO  = 2'd2,
    MODE_HOLD3 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // Default stimulus held at indices 0..3 after reset; other entries are zero
  localparam int DEFAULT_LEN = 4;
  localparam int DEFAULT_STIM [DEFAULT_LEN] = '{2, 3, -2, 8};

  // Reset value of table entry i
  function automatic int default_entry(input int i);
    if (i >= 0 && i < DEFAULT_LEN) return DEFAULT_STIM[i[1:0]];
    return 0;
  endfunction

endpackage

// File: rtl/fir_stimgen_table.sv
// Stimulus table: synchronous write port, combinational read port.
// Reset reloads the default stimulus and takes priority over a write.
module fir_stimgen_table #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);
  import FIR_types::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic signed [DATA_W-1:0] mem [DEPTH];

  // Addresses past DEPTH exist when DEPTH is not a power of two
  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

  // Table storage: reset load of the default stimulus, else write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(default_entry(i));
      end
    end else if (wr_en && wr_in_range) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so a write shows up on the very next cycle
  always_comb begin
    rd_data = '0;
    if (rd_in_range) rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/fir_stimgen_param.sv
// FIR stimulus generator: plays a programmable table as a valid/ready
// sample stream, with HOLD / LOOP / ZERO behaviour after the last entry.
module fir_stimgen_param #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [1:0]               mode,
  input  logic [ADDR_W:0]          len,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     done
);
  import FIR_types::*;

  // Index arithmetic is one bit wider than the address so len_q=DEPTH fits
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t          state;
  mode_t           mode_q;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] len_q;

  logic [ADDR_W:0]          len_eff;
  logic [ADDR_W:0]          last_idx;
  logic [ADDR_W:0]          rd_sel;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     accept;
  logic                     is_last;

  // A zero or oversized length plays the whole table
  assign len_eff  = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
  assign last_idx = len_q - ONE_L;
  assign is_last  = (idx == last_idx);
  assign accept   = out_valid && out_ready;

  // TAIL reads the last entry of the sequence; RUN reads the live index
  assign rd_sel  = (state == ST_TAIL) ? last_idx : idx;
  assign rd_addr = rd_sel[ADDR_W-1:0];

  fir_stimgen_table #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (system1000),
    .rst     (system1000_rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Sequencer: reset beats stop, stop beats start, start beats the handshake
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      mode_q <= MODE_HOLD;
      len_q  <= DEPTH_L;
    end else if (stop) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else if (start) begin
      state  <= ST_RUN;
      idx    <= '0;
      mode_q <= mode_t'(mode);
      len_q  <= len_eff;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) begin
            if (is_last) begin
              idx <= '0;
              if (mode_q != MODE_LOOP) state <= ST_TAIL;
            end else begin
              idx <= idx + ONE_L;
            end
          end
        end
        ST_TAIL: begin
          state <= ST_TAIL;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = (state != ST_IDLE);

  // Acceptance of the final entry is flagged in the same cycle
  assign done = (state == ST_RUN) && out_ready && is_last;

  // Sample mux: silent in IDLE, table in RUN, held or zero in TAIL
  always_comb begin
    out_data = '0;
    case (state)
      ST_RUN:  out_data = rd_data;
      ST_TAIL: out_data = (mode_q == MODE_ZERO) ? '0 : rd_data;
      default: out_data = '0;
    endcase
  end

endmodule

// File: tb/tb_fir_stimgen_param.sv
// Directed bench for fir_stimgen_param: each step queues the expected
// valid/data/done for the cycle and the sampler pops and compares it.
module tb_fir_stimgen_param;

  logic              system1000 = 1'b0;
  logic              system1000_rst;
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [3:0]        len;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic signed [15:0] wr_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_data;
  logic              done;

  typedef struct {
    logic               v;
    logic signed [15:0] d;
    logic               dn;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   step_no = 0;

  fir_stimgen_param #(.DATA_W(16), .DEPTH(8)) dut (
    .system1000     (system1000),
    .system1000_rst (system1000_rst),
    .start          (start),
    .stop           (stop),
    .mode           (mode),
    .len            (len),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .done           (done)
  );

  always #5 system1000 = ~system1000;

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s step %0d: observed %0d expected %0d", tag, step_no, obs, exp);
    end
  endtask

  // Pop one expectation and compare mid-cycle, away from the rising edge
  task automatic sample();
    exp_t e;
    #3;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard step %0d: observed empty queue expected entry", step_no);
    end else begin
      e = exp_q.pop_front();
      chk("out_valid", out_valid, e.v);
      chk("out_data", out_data, e.d);
      chk("done", done, e.dn);
    end
  endtask

  // One clock: drive ready, queue the expectation, check, advance, clear pulses
  task automatic cyc(input logic rdy, input logic v, input int d, input logic dn);
    exp_t e;
    out_ready = rdy;
    e.v = v;
    e.d = 16'(d);
    e.dn = dn;
    exp_q.push_back(e);
    sample();
    @(posedge system1000);
    #1;
    step_no++;
    start = 1'b0;
    stop = 1'b0;
    wr_en = 1'b0;
    system1000_rst = 1'b0;
  endtask

  initial begin
    system1000_rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    mode = 2'd0;
    len = 4'd0;
    wr_en = 1'b0;
    wr_addr = 3'd0;
    wr_data = 16'sd0;
    out_ready = 1'b0;
    repeat (2) @(posedge system1000);
    #1;

    // Reset state: idle and silent
    cyc(1'b0, 1'b0, 0, 1'b0);

    // HOLD, len 4: 2,3,-2,8 then 8 forever; done with the 8
    start = 1'b1; len = 4'd4; mode = 2'd0;
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, -2, 1'b0);
    cyc(1'b1, 1'b1, 8, 1'b1);
    cyc(1'b1, 1'b1, 8, 1'b0);
    cyc(1'b1, 1'b1, 8, 1'b0);

    // LOOP, len 4: wraps, done every fourth sample
    start = 1'b1; len = 4'd4; mode = 2'd1;
    cyc(1'b1, 1'b1, 8, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, -2, 1'b0);
    cyc(1'b1, 1'b1, 8, 1'b1);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, -2, 1'b0);
    cyc(1'b1, 1'b1, 8, 1'b1);
    cyc(1'b1, 1'b1, 2, 1'b0);

    // Restart from RUN in ZERO, len 3, ready toggling
    start = 1'b1; len = 4'd3; mode = 2'd2;
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b1, -2, 1'b0);
    cyc(1'b1, 1'b1, -2, 1'b1);
    cyc(1'b0, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0);

    // Write table[1]=100 while stalled at idx 1
    start = 1'b1; len = 4'd4; mode = 2'd0;
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'sd100;
    cyc(1'b0, 1'b1, 3, 1'b0);
    cyc(1'b0, 1'b1, 100, 1'b0);
    cyc(1'b1, 1'b1, 100, 1'b0);
    cyc(1'b1, 1'b1, -2, 1'b0);

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1; len = 4'd4; mode = 2'd1;
    cyc(1'b0, 1'b1, 8, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'sd3;
    cyc(1'b1, 1'b0, 0, 1'b0);

    // len 0 plays all eight entries
    start = 1'b1; len = 4'd0; mode = 2'd0;
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b1, -2, 1'b0);
    cyc(1'b1, 1'b1, 8, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 0, 1'b1);
    cyc(1'b1, 1'b1, 0, 1'b0);

    // LOOP after writing table[0]=7, then reset at idx 2 reloads the table
    start = 1'b1; len = 4'd4; mode = 2'd1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'sd7;
    cyc(1'b1, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b1, 7, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);
    system1000_rst = 1'b1; start = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'sd55;
    cyc(1'b1, 1'b1, -2, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0);
    start = 1'b1; len = 4'd4; mode = 2'd0;
    cyc(1'b1, 1'b0, 0, 1'b0);
    cyc(1'b1, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b1, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
